dif_butterfly_unit: RTL
=======================

DIF_BUTTERFLY_UNIT -- requirements
Module: dif_butterfly_unit

Interface
REQ-001 Parameter DATA_W, default 16: signed data/twiddle width in Q1.(DATA_W-1); verified at 16 only.
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 i_valid  in  1  input pair and twiddle valid.
REQ-005 o_ready  out  1  block accepts input this cycle.
REQ-006 i_data_ra, i_data_ca, i_data_rb, i_data_cb  in  16 each  operands A, B (real, imag).
REQ-007 i_twiddle_r, i_twiddle_c  in  16 each  twiddle W.
REQ-008 i_inverse  in  1  1 = use conj(W) (IFFT); sampled with the input.
REQ-009 i_scale  in  1  1 = halve both outputs; sampled with the input.
REQ-010 o_valid  out  1  outputs valid.
REQ-011 i_ready  in  1  downstream accepts output.
REQ-012 o_data_ra, o_data_ca, o_data_rb, o_data_cb  out  16 each  results A', B'.
REQ-013 o_ovf  out  1  sticky saturation flag.
REQ-014 i_ovf_clr  in  1  clears o_ovf.

Function
REQ-015 Decimation-in-frequency butterfly: A' = A + B; B' = (A - B) * W, or (A - B) * conj(W) when i_inverse=1.
REQ-016 Three register stages: S1 = 17-bit sum/difference; S2 = full-precision complex product; S3 = round, scale, saturate. Latency is exactly 3 cycles from input handshake to o_valid when i_ready stays high.
REQ-017 Handshake: a transfer occurs when valid and ready are both high.
REQ-018 Global enable: en = ~o_valid | i_ready. o_ready = en, and all stages advance only when en=1.
REQ-019 Stall behaviour: while o_valid=1 and i_ready=0, all outputs, including o_valid, SHALL hold stable.
REQ-020 No data loss, duplication or reordering occurs under arbitrary i_valid/i_ready patterns; bubbles propagate as valid=0.
REQ-021 i_inverse and i_scale travel with their data through the pipeline.
REQ-022 Product: 17x16 signed multiplies with a 34-bit accumulate.
  - forward: real = dr*wr - dc*wc; imag = dr*wc + dc*wr.
  - inverse: real = dr*wr + dc*wc; imag = dc*wr - dr*wc.
REQ-023 Product rounding: add 2^14, then arithmetic shift right by 15; round half up.
REQ-024 Scale: when i_scale=1, the pre-saturation value v becomes (v+1)>>>1, with the same rounding rule, for both A' and B'.
REQ-025 Saturation: results outside [-32768, 32767] clamp to 0x8000/0x7FFF; 0x8000 is a legal twiddle (-1.0).
REQ-026 o_ovf is set on any clamp of an output that is actually transferred valid.
REQ-027 o_ovf is cleared by i_ovf_clr; if set and clear occur in the same cycle, set wins.
REQ-028 When o_valid=0, output data values are don't-care but deterministic.

Reset
REQ-029 On rst assertion, immediately (asynchronously) clear all stage valids, o_valid and o_ovf, and zero all data registers and outputs; o_ready=1 once rst deasserts.
REQ-030 Reset mid-stream discards all in-flight data; no outputs are emitted for it after reset.

Structure
REQ-031 The shared package fft_pkg holds DATA_W, FRAC_W=15, the Q1.15 MAX/MIN constants, and the round/saturate function.
REQ-032 One sub-module, dif_cmult_round, implements the S2/S3 complex multiply with conjugate select and rounding; the sum path stays inline.

Verification (all values hex Q1.15, i_ready=1 unless stated)
REQ-033 A=(2000,0), B=(1000,0), W=(7FFF,0), fwd, scale=0 -> 3 cycles later A'=(3000,0), B'=(1000,0), o_ovf=0.
REQ-034 A=B=(7000,0), W=(7FFF,0), scale=0 -> A'r=7FFF and o_ovf=1; same input with scale=1 -> A'=(7000,0) and o_ovf stays as before.
REQ-035 A=(1000,0), B=0, W=(0,8000):
  - fwd -> B'=(0,F000);
  - inverse -> B'=(0,1000);
  - A'=(1000,0) in both cases.
REQ-036 Stream 8 back-to-back inputs, drop i_ready for 4 cycles after the 2nd output -> o_ready low, outputs held, all 8 emitted in order, none lost.
REQ-037 Assert rst with 3 items in flight and o_ovf=1 -> o_valid=0 and o_ovf=0 immediately; no stale output after release.
REQ-038 Assert i_ovf_clr in the same cycle as a new saturating output -> o_ovf remains 1; a clear on the following cycle -> 0.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared widths, Q1.15 limits and the round/saturate helpers
// used by the DIF butterfly datapath.
package fft_pkg;

    localparam int DATA_W = 16;
    localparam int FRAC_W = 15;
    localparam int SUM_W  = DATA_W + 1;
    localparam int PROD_W = 2 * DATA_W + 2;
    localparam int RND_W  = PROD_W - FRAC_W;

    localparam logic signed [DATA_W-1:0] Q_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] Q_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    typedef struct packed {
        logic [DATA_W-1:0] val;
        logic              clip;
    } sat_t;

    // Round half up: add 2^(FRAC_W-1), then arithmetic shift by FRAC_W.
    function automatic logic signed [RND_W-1:0] round_prod(
        input logic signed [PROD_W-1:0] p
    );
        logic signed [PROD_W-1:0] t;
        t = p + (PROD_W'(1) << (FRAC_W - 1));
        return t[PROD_W-1:FRAC_W];
    endfunction

    function automatic sat_t round_sat(
        input logic signed [RND_W-1:0] v,
        input logic                    scale
    );
        logic signed [RND_W-1:0] s;
        sat_t r;
        s = scale ? (v + RND_W'(1)) >>> 1 : v;
        r.clip = 1'b1;
        if (s > RND_W'(Q_MAX)) begin
            r.val = Q_MAX;
        end else if (s < RND_W'(Q_MIN)) begin
            r.val = Q_MIN;
        end else begin
            r.val  = s[DATA_W-1:0];
            r.clip = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/dif_cmult_round.sv
// Complex multiply of the butterfly difference by W or conj(W):
// full-precision product register, then round/scale/saturate register.
module dif_cmult_round
    import fft_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic signed [SUM_W-1:0]  d_r,
    input  logic signed [SUM_W-1:0]  d_c,
    input  logic signed [DATA_W-1:0] w_r,
    input  logic signed [DATA_W-1:0] w_c,
    input  logic                     inverse,
    input  logic                     scale,
    output logic [DATA_W-1:0]        y_r,
    output logic [DATA_W-1:0]        y_c,
    output logic                     clip
);

    logic signed [PROD_W-1:0] dr_x, dc_x, wr_x, wc_x;
    logic signed [PROD_W-1:0] m_rr, m_cc, m_rc, m_cr;
    logic signed [PROD_W-1:0] acc_r, acc_c;
    logic signed [PROD_W-1:0] p_r, p_c;
    sat_t q_r, q_c;

    always_comb begin
        dr_x = PROD_W'(d_r);
        dc_x = PROD_W'(d_c);
        wr_x = PROD_W'(w_r);
        wc_x = PROD_W'(w_c);
        m_rr = dr_x * wr_x;
        m_cc = dc_x * wc_x;
        m_rc = dr_x * wc_x;
        m_cr = dc_x * wr_x;
        // conj(W) flips the sign of every wc term
        if (inverse) begin
            acc_r = m_rr + m_cc;
            acc_c = m_cr - m_rc;
        end else begin
            acc_r = m_rr - m_cc;
            acc_c = m_rc + m_cr;
        end
        q_r = round_sat(round_prod(p_r), scale);
        q_c = round_sat(round_prod(p_c), scale);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_r  <= '0;
            p_c  <= '0;
            y_r  <= '0;
            y_c  <= '0;
            clip <= 1'b0;
        end else if (en) begin
            p_r  <= acc_r;
            p_c  <= acc_c;
            y_r  <= q_r.val;
            y_c  <= q_c.val;
            clip <= q_r.clip | q_c.clip;
        end
    end

endmodule

// File: rtl/dif_butterfly_unit.sv
// Radix-2 DIF butterfly: A' = A + B, B' = (A - B) * W (or conj W),
// three-stage pipeline with a single global stall enable.
module dif_butterfly_unit #(
    parameter int DATA_W = fft_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_data_ra,
    input  logic [DATA_W-1:0] i_data_ca,
    input  logic [DATA_W-1:0] i_data_rb,
    input  logic [DATA_W-1:0] i_data_cb,
    input  logic [DATA_W-1:0] i_twiddle_r,
    input  logic [DATA_W-1:0] i_twiddle_c,
    input  logic              i_inverse,
    input  logic              i_scale,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data_ra,
    output logic [DATA_W-1:0] o_data_ca,
    output logic [DATA_W-1:0] o_data_rb,
    output logic [DATA_W-1:0] o_data_cb,
    output logic              o_ovf,
    input  logic              i_ovf_clr
);

    import fft_pkg::*;

    logic                     en;
    logic                     s1_valid, s1_inv, s1_scale;
    logic signed [SUM_W-1:0]  s1_sr, s1_sc, s1_dr, s1_dc;
    logic signed [DATA_W-1:0] s1_wr, s1_wc;
    logic                     s2_valid, s2_scale;
    logic signed [SUM_W-1:0]  s2_sr, s2_sc;
    logic                     a_clip, b_clip;
    sat_t                     a_r, a_c;

    assign en      = ~o_valid | i_ready;
    assign o_ready = en;

    always_comb begin
        a_r = round_sat(RND_W'(s2_sr), s2_scale);
        a_c = round_sat(RND_W'(s2_sc), s2_scale);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_inv    <= 1'b0;
            s1_scale  <= 1'b0;
            s1_sr     <= '0;
            s1_sc     <= '0;
            s1_dr     <= '0;
            s1_dc     <= '0;
            s1_wr     <= '0;
            s1_wc     <= '0;
            s2_valid  <= 1'b0;
            s2_scale  <= 1'b0;
            s2_sr     <= '0;
            s2_sc     <= '0;
            o_valid   <= 1'b0;
            o_data_ra <= '0;
            o_data_ca <= '0;
            a_clip    <= 1'b0;
            o_ovf     <= 1'b0;
        end else begin
            if (en) begin
                s1_valid  <= i_valid;
                s1_inv    <= i_inverse;
                s1_scale  <= i_scale;
                s1_sr     <= {i_data_ra[DATA_W-1], i_data_ra}
                           + {i_data_rb[DATA_W-1], i_data_rb};
                s1_sc     <= {i_data_ca[DATA_W-1], i_data_ca}
                           + {i_data_cb[DATA_W-1], i_data_cb};
                s1_dr     <= {i_data_ra[DATA_W-1], i_data_ra}
                           - {i_data_rb[DATA_W-1], i_data_rb};
                s1_dc     <= {i_data_ca[DATA_W-1], i_data_ca}
                           - {i_data_cb[DATA_W-1], i_data_cb};
                s1_wr     <= i_twiddle_r;
                s1_wc     <= i_twiddle_c;
                s2_valid  <= s1_valid;
                s2_scale  <= s1_scale;
                s2_sr     <= s1_sr;
                s2_sc     <= s1_sc;
                o_valid   <= s2_valid;
                o_data_ra <= a_r.val;
                o_data_ca <= a_c.val;
                a_clip    <= a_r.clip | a_c.clip;
            end
            // a clamp only counts once its result leaves the block
            o_ovf <= (o_valid & i_ready & (a_clip | b_clip))
                   | (o_ovf & ~i_ovf_clr);
        end
    end

    dif_cmult_round u_cmult (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .d_r     (s1_dr),
        .d_c     (s1_dc),
        .w_r     (s1_wr),
        .w_c     (s1_wc),
        .inverse (s1_inv),
        .scale   (s2_scale),
        .y_r     (o_data_rb),
        .y_c     (o_data_cb),
        .clip    (b_clip)
    );

endmodule
